vga_timing_gen: RTL and testbench

- Produces the raster scan that every pixel-side consumer in the display path reads: DrawX, DrawY, blank, hsync and vsync.
- Sprite and palette renderers sample DrawX/DrawY/blank and drive RGB on vga_clk.
- This block is the single source of those signals, plus frame-level strobes for animation logic.
- Default timing is 640x480@60 at a 25 MHz vga_clk.

---
 rtl/vga_timing_gen_if.sv | 23 ++
 rtl/vga_timing_gen.sv | 101 ++++++++++
 tb/tb_vga_timing_gen.sv | 133 +++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// Raster-scan bundle shared by the timing generator and the pixel-side
// consumers (sprite/palette renderers, animation logic).
interface vga_timing_gen_if;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       blank;
  logic       hsync;
  logic       vsync;
  logic       line_start;
  logic       frame_start;
  logic       vblank_start;
  logic [7:0] frame_count;

  modport master (
    output DrawX, DrawY, blank, hsync, vsync,
    output line_start, frame_start, vblank_start, frame_count
  );

  modport slave (
    input DrawX, DrawY, blank, hsync, vsync,
    input line_start, frame_start, vblank_start, frame_count
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator. A free-running (hc,vc) counter pair is
// decoded one step ahead, so every registered output describes the
// DrawX/DrawY presented in the same cycle.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  vga_timing_gen_if.master  vga
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  // Counts are 10 bits wide; larger totals cannot be represented.
  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_size_check
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end

  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_VIS10  = 10'(V_VISIBLE);
  // 11-bit bounds so a sync pulse ending exactly at 1024 is still expressible.
  localparam logic [10:0] H_VIS11  = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS11  = 11'(V_VISIBLE);
  localparam logic [10:0] HS_BEG   = 11'(H_VISIBLE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [10:0] VS_BEG   = 11'(V_VISIBLE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FP + V_SYNC);

  logic [9:0] hc;
  logic [9:0] vc;
  logic [9:0] hc_nxt;
  logic [9:0] vc_nxt;
  logic       wrap_line;
  logic       wrap_frame;

  function automatic logic in_window(input logic [9:0] pos,
                                     input logic [10:0] lo,
                                     input logic [10:0] hi);
    return ({1'b0, pos} >= lo) && ({1'b0, pos} < hi);
  endfunction

  // Next count: hc wraps every line, vc advances on hc wrap.
  always_comb begin
    wrap_line  = (hc == H_LAST);
    wrap_frame = wrap_line && (vc == V_LAST);
    hc_nxt     = hc + 10'd1;
    vc_nxt     = vc;
    if (wrap_line) begin
      hc_nxt = '0;
      vc_nxt = wrap_frame ? 10'd0 : vc + 10'd1;
    end
  end

  // Count state; reset parks on the last position so the first edge wraps to (0,0).
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hc <= H_LAST;
      vc <= V_LAST;
    end else begin
      hc <= hc_nxt;
      vc <= vc_nxt;
    end
  end

  // Registered outputs decoded from the next count.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      vga.DrawX        <= '0;
      vga.DrawY        <= '0;
      vga.blank        <= 1'b0;
      vga.hsync        <= 1'b1;
      vga.vsync        <= 1'b1;
      vga.line_start   <= 1'b0;
      vga.frame_start  <= 1'b0;
      vga.vblank_start <= 1'b0;
      vga.frame_count  <= '0;
    end else begin
      vga.DrawX        <= hc_nxt;
      vga.DrawY        <= vc_nxt;
      vga.blank        <= ({1'b0, hc_nxt} < H_VIS11) && ({1'b0, vc_nxt} < V_VIS11);
      vga.hsync        <= !in_window(hc_nxt, HS_BEG, HS_END);
      vga.vsync        <= !in_window(vc_nxt, VS_BEG, VS_END);
      vga.line_start   <= (hc_nxt == 10'd0);
      vga.frame_start  <= (hc_nxt == 10'd0) && (vc_nxt == 10'd0);
      vga.vblank_start <= (hc_nxt == 10'd0) && (vc_nxt == V_VIS10);
      if (wrap_frame) begin
        vga.frame_count <= vga.frame_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a reduced raster (8x4 visible) so that more
// than 256 frames fit in a short run. Expected outputs come from the cycle
// index since reset release, using plain div/mod arithmetic.
`timescale 1ns/1ps
module tb_vga_timing_gen;

  localparam int HV = 8, HF = 2, HS = 2, HB = 2;
  localparam int VV = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = HV + HF + HS + HB;   // 14
  localparam int VT = VV + VF + VS + VB;   // 8
  localparam int FRAME = HT * VT;          // 112

  logic vga_clk = 1'b0;
  logic reset_n = 1'b0;

  vga_timing_gen_if vif ();

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .vga_clk (vga_clk),
    .reset_n (reset_n),
    .vga     (vif)
  );

  always #5 vga_clk = ~vga_clk;

  int checks = 0;
  int errors = 0;
  int cur_t  = -1;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at t=%0d: got %0d, expected %0d", tag, cur_t, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_x"},   int'(vif.DrawX), 0);
    chk({tag, "_y"},   int'(vif.DrawY), 0);
    chk({tag, "_blk"}, int'(vif.blank), 0);
    chk({tag, "_hs"},  int'(vif.hsync), 1);
    chk({tag, "_vs"},  int'(vif.vsync), 1);
    chk({tag, "_ls"},  int'(vif.line_start), 0);
    chk({tag, "_fs"},  int'(vif.frame_start), 0);
    chk({tag, "_vbs"}, int'(vif.vblank_start), 0);
    chk({tag, "_fc"},  int'(vif.frame_count), 0);
  endtask

  // Called at a negedge with reset_n low: release between edges, then
  // check every cycle against the arithmetic raster model.
  task automatic run_segment(input int ncycles);
    int last_fs;
    int blank_cnt;
    int x, y, f;
    last_fs   = -1;
    blank_cnt = 0;
    cur_t     = -1;
    #2 reset_n = 1'b1;
    #1 chk_reset_vals("pre_edge");
    for (int t = 0; t < ncycles; t++) begin
      @(posedge vga_clk);
      @(negedge vga_clk);
      cur_t = t;
      x = t % HT;
      y = (t / HT) % VT;
      f = (t / FRAME + 1) % 256;
      chk("DrawX", int'(vif.DrawX), x);
      chk("DrawY", int'(vif.DrawY), y);
      chk("blank", int'(vif.blank), int'(x < HV && y < VV));
      chk("hsync", int'(vif.hsync), int'(!(x >= HV + HF && x < HV + HF + HS)));
      chk("vsync", int'(vif.vsync), int'(!(y >= VV + VF && y < VV + VF + VS)));
      chk("line_start", int'(vif.line_start), int'(x == 0));
      chk("frame_start", int'(vif.frame_start), int'(x == 0 && y == 0));
      chk("vblank_start", int'(vif.vblank_start), int'(x == 0 && y == VV));
      chk("frame_count", int'(vif.frame_count), f);
      if (vif.frame_start === 1'b1) begin
        if (last_fs >= 0) begin
          chk("frame_period", t - last_fs, FRAME);
          chk("blank_per_frame", blank_cnt, HV * VV);
        end
        last_fs   = t;
        blank_cnt = 0;
      end
      if (vif.blank === 1'b1) blank_cnt++;
    end
  endtask

  // Called at a negedge: assert reset between edges and hold it a few cycles.
  task automatic async_reset();
    int hold;
    hold = int'($urandom_range(1, 3));
    #3 reset_n = 1'b0;
    #1 cur_t = -1;
    chk_reset_vals("async_rst");
    for (int i = 0; i < hold; i++) begin
      @(negedge vga_clk);
      chk_reset_vals("rst_hold");
    end
  endtask

  initial begin
    repeat (3) @(negedge vga_clk);
    chk_reset_vals("por");

    // Short random segments, each ending mid-frame with an async reset.
    for (int s = 0; s < 5; s++) begin
      run_segment(int'($urandom_range(30, 600)));
      async_reset();
    end

    // Long run: more than 256 frames so frame_count wraps 255->0 on frame_start.
    run_segment(257 * FRAME + int'($urandom_range(5, 60)));
    async_reset();

    // Restart sequence after a mid-frame reset must match the first frame again.
    run_segment(3 * FRAME + 7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time bound so the bench can never hang.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time budget, got running, expected finished");
    $fatal(1);
  end

endmodule
